// File: rtl/draw_scheduler_if.sv
// Drawer-side and VGA-side signals of the draw scheduler, bundled for one port.
interface draw_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int X_W     = 9,
   parameter int Y_W     = 8,
   parameter int C_W     = 3
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     drw_done;
   logic [NUM_REQ*X_W-1:0] drw_x;
   logic [NUM_REQ*Y_W-1:0] drw_y;
   logic [NUM_REQ*C_W-1:0] drw_colour;
   logic [NUM_REQ-1:0]     drw_enable;
   logic [NUM_REQ-1:0]     drw_reset_n;
   logic [NUM_REQ-1:0]     grant;
   logic                   busy;
   logic                   job_done;
   logic [ID_W-1:0]        job_id;
   logic [X_W-1:0]         vga_x;
   logic [Y_W-1:0]         vga_y;
   logic [C_W-1:0]         vga_colour;
   logic                   vga_plot;

   modport master (
      input  req, drw_done, drw_x, drw_y, drw_colour,
      output drw_enable, drw_reset_n, grant, busy, job_done, job_id,
             vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      output req, drw_done, drw_x, drw_y, drw_colour,
      input  drw_enable, drw_reset_n, grant, busy, job_done, job_id,
             vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/draw_scheduler.sv
// Round-robin owner of the VGA write port; x/y reach vga after PIPE_LAT+1 cycles, colour after 1.
// No backpressure: a drawer is paced only by its enable and runs until its done flag.
module draw_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int C_W      = 3,
   parameter int PIPE_LAT = 1
) (
   input logic              clock_all,
   input logic              reset_all,
   draw_scheduler_if.master bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [1:0] {IDLE, PREP, RUN, DRAIN} state_t;

   typedef struct packed {
      logic           vld;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pix_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  gidx;
   logic [ID_W-1:0]  win_idx;
   logic             win_found;
   logic [CNT_W-1:0] drain_cnt;
   int               k;
   pix_t             raw_pix;
   pix_t             pix_pipe [PIPE_LAT];
   pix_t             pix_out;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // First requester at or after the pointer, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      k         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = (int'(rr_ptr) + i) % NUM_REQ;
         if (!win_found && bus.req[k]) begin
            win_found = 1'b1;
            win_idx   = k[ID_W-1:0];
         end
      end
   end

   always_comb begin
      raw_pix.vld = (state == RUN);
      raw_pix.x   = bus.drw_x[gidx*X_W +: X_W];
      raw_pix.y   = bus.drw_y[gidx*Y_W +: Y_W];
   end

   assign pix_out = pix_pipe[PIPE_LAT-1];

   // x/y/valid wait here so they meet the drawer's ROM colour at the output register.
   always_ff @(posedge clock_all or negedge reset_all) begin
      if (!reset_all) begin
         for (int i = 0; i < PIPE_LAT; i++) pix_pipe[i] <= '0;
      end else begin
         pix_pipe[0] <= raw_pix;
         for (int i = 1; i < PIPE_LAT; i++) pix_pipe[i] <= pix_pipe[i-1];
      end
   end

   always_ff @(posedge clock_all or negedge reset_all) begin
      if (!reset_all) begin
         bus.vga_plot   <= 1'b0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
      end else begin
         bus.vga_plot <= pix_out.vld;
         if (pix_out.vld) begin
            bus.vga_x      <= pix_out.x;
            bus.vga_y      <= pix_out.y;
            bus.vga_colour <= bus.drw_colour[gidx*C_W +: C_W];
         end
      end
   end

   always_ff @(posedge clock_all or negedge reset_all) begin
      if (!reset_all) begin
         state           <= IDLE;
         bus.grant       <= '0;
         bus.drw_enable  <= '0;
         bus.drw_reset_n <= '0;
         bus.busy        <= 1'b0;
         bus.job_done    <= 1'b0;
         bus.job_id      <= '0;
         rr_ptr          <= '0;
         gidx            <= '0;
         drain_cnt       <= '0;
      end else begin
         bus.job_done <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  gidx            <= win_idx;
                  bus.grant       <= onehot(win_idx);
                  bus.drw_reset_n <= onehot(win_idx);
                  bus.busy        <= 1'b1;
                  state           <= PREP;
               end
            end
            PREP: begin
               bus.drw_enable <= onehot(gidx);
               state          <= RUN;
            end
            RUN: begin
               if (bus.drw_done[gidx]) begin
                  bus.drw_enable <= '0;
                  drain_cnt      <= '0;
                  state          <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_cnt == CNT_W'(PIPE_LAT - 1)) begin
                  bus.grant       <= '0;
                  bus.drw_reset_n <= '0;
                  bus.busy        <= 1'b0;
                  bus.job_done    <= 1'b1;
                  bus.job_id      <= gidx;
                  rr_ptr          <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
                  state           <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
